// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller.
//   state_t       : fetch FSM encoding (2 bits)
//   fetch_entry_t : one instruction queue entry {pc, inst}
//   PC_STEP / NOP : sequential fetch increment and empty-slot instruction value
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  localparam logic [31:0] PC_STEP = 32'd4;
  localparam logic [31:0] NOP     = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  // Sequential successor; wraps modulo 2^32 by construction.
  function automatic logic [31:0] next_pc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle.
//   Memory side : mem_req, mem_addr (ctrl -> mem); mem_ack, mem_rdata (mem -> ctrl)
//   Decode side : inst_valid, inst, inst_pc (ctrl -> decode); inst_ready (decode -> ctrl)
//   master modport is the fetch controller, slave modport is its environment.
interface fetch_ctrl_if;

  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    output mem_req, mem_addr, inst_valid, inst, inst_pc,
    input  mem_ack, mem_rdata, inst_ready
  );

  modport slave (
    input  mem_req, mem_addr, inst_valid, inst, inst_pc,
    output mem_ack, mem_rdata, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Two-entry instruction queue organised as a shift pair: entry 0 is always
// the head, so head/head_valid come straight from flops.
//   clk, rst_n : clock, async active-low reset
//   push, din  : enqueue request and data (ignored when full without a pop)
//   pop        : dequeue head (ignored when empty)
//   clear      : drop all entries; overrides push and pop
//   head       : head entry, head_valid : queue not empty, count : 0..2
module fetch_fifo
  import fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic         head_valid,
  output logic [1:0]   count
);

  fetch_entry_t entry1;
  logic         do_push;
  logic         do_pop;
  logic [1:0]   count_nxt;

  always_comb begin
    do_pop    = pop && (count != 2'd0);
    do_push   = push && ((count != 2'd2) || do_pop);
    count_nxt = count + {1'b0, do_push} - {1'b0, do_pop};
    if (clear) begin
      count_nxt = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head       <= '{pc: 32'h0, inst: NOP};
      entry1     <= '{pc: 32'h0, inst: NOP};
      count      <= 2'd0;
      head_valid <= 1'b0;
    end else begin
      count      <= count_nxt;
      head_valid <= (count_nxt != 2'd0);
      if (!clear) begin
        case ({do_push, do_pop})
          2'b10: begin
            if (count == 2'd0) head <= din;
            else               entry1 <= din;
          end
          2'b01: head <= entry1;
          2'b11: begin
            if (count == 2'd1) begin
              head <= din;
            end else begin
              head   <= entry1;
              entry1 <= din;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one memory read at a time, queues
// returned words with their address, and handles redirects (jmp) including
// a request already on the bus, whose late response is drained and dropped.
//   clk, rst_n   : clock, async active-low reset
//   hazard_stall : blocks dequeue only; fetching continues
//   jmp, dest    : one-cycle redirect and its target (word aligned internally)
//   bus          : fetch_ctrl_if.master (memory request side + decode side)
//
// state    | meaning
// ---------+--------------------------------------------------------
// ST_IDLE  | one cycle after reset release, no request
// ST_REQ   | request to fetch_pc on the bus
// ST_DRAIN | killed request on the bus, response will be discarded
// ST_FULL  | queue full, request withheld until the decoder pops
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hazard_stall,
  input  logic         jmp,
  input  logic [31:0]  dest,
  fetch_ctrl_if.master bus
);

  localparam logic [2:0] QDEPTH_W = 3'(QDEPTH);

  state_t       state, state_nxt;
  logic [31:0]  fetch_pc, fetch_pc_nxt;
  logic [31:0]  kill_addr, kill_addr_nxt;
  logic         mem_req;
  logic         push, pop, clear;
  logic [2:0]   post_cnt;
  logic [1:0]   count;
  fetch_entry_t head;
  logic         head_valid;

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .pop        (pop),
    .clear      (clear),
    .din        ('{pc: fetch_pc, inst: bus.mem_rdata}),
    .head       (head),
    .head_valid (head_valid),
    .count      (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      fetch_pc  <= RESET_PC;
      kill_addr <= RESET_PC;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      kill_addr <= kill_addr_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    fetch_pc_nxt  = fetch_pc;
    kill_addr_nxt = kill_addr;
    mem_req       = 1'b0;
    push          = 1'b0;
    clear         = 1'b0;
    pop           = head_valid & bus.inst_ready & ~hazard_stall & ~jmp;
    // Occupancy after this edge if the current response is pushed.
    post_cnt      = {1'b0, count} + 3'd1 - {2'b00, pop};

    case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        mem_req = 1'b1;
        if (bus.mem_ack) begin
          push         = 1'b1;
          fetch_pc_nxt = next_pc(fetch_pc);
          state_nxt    = (post_cnt >= QDEPTH_W) ? ST_FULL : ST_REQ;
        end
      end
      ST_DRAIN: begin
        mem_req = 1'b1;
        if (bus.mem_ack) state_nxt = ST_REQ;
      end
      ST_FULL: begin
        if (pop) state_nxt = ST_REQ;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Redirect overrides everything decided above.
    if (jmp) begin
      clear        = 1'b1;
      push         = 1'b0;
      fetch_pc_nxt = dest & ~32'h3;
      if (mem_req && !bus.mem_ack) begin
        state_nxt = ST_DRAIN;
        // A second jmp while draining must keep the original bus address.
        if (state != ST_DRAIN) kill_addr_nxt = fetch_pc;
      end else begin
        state_nxt = ST_REQ;
      end
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_addr   = (state == ST_DRAIN) ? kill_addr : fetch_pc;
  assign bus.inst_valid = head_valid;
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;

endmodule
